// File: rtl/amba3_apb_arbiter_pkg.sv
// Shared types for the AMBA 3 APB arbiter slice.
package pkg_amba3;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_t;

  localparam int unsigned APB_ADDR_BITS_DEF = 32;
  localparam int unsigned APB_DATA_BITS_DEF = 32;

endpackage

// File: rtl/amba3_apb_arbiter_if.sv
// AMBA 3 APB signal bundle between the arbiter (master) and the slave fabric.
interface amba3_apb_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);

  logic [ADDR_BITS-1:0] paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [DATA_BITS-1:0] pwdata;
  logic                 pready;
  logic [DATA_BITS-1:0] prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata
  );

endinterface

// File: rtl/amba3_apb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module amba3_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan N positions starting just above the last grant; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/amba3_apb_arbiter.sv
// Shares one APB master port among NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing and a registered completion pulse.
module amba3_apb_arbiter
  import pkg_amba3::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_BITS-1:0]           rsp_rdata,
  amba3_apb_if.master                    apb
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     last_q, owner_q, win_idx;
  logic [NUM_REQ-1:0]   win_gnt;
  logic                 grant_ok, grant, xfer_done;

  logic [ADDR_BITS-1:0] paddr_q, paddr_d;
  logic [DATA_BITS-1:0] pwdata_q, pwdata_d;
  logic                 pwrite_q, pwrite_d;
  logic                 psel_q, penable_q;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;

  // Grant points: bus idle, or the current transfer completing this cycle.
  // Gated by reset so req_ready stays low while reset is asserted.
  always_comb begin
    xfer_done = (state_q == APB_ACCESS) && apb.pready;
    grant_ok  = preset_n && ((state_q == APB_IDLE) || xfer_done);
  end

  amba3_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (last_q),
    .en      (grant_ok),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  assign grant     = |win_gnt;
  assign req_ready = win_gnt;

  // Next state plus next APB/response register values.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      APB_IDLE:   if (grant) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (apb.pready) state_d = grant ? APB_SETUP : APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase

    if (grant) begin
      paddr_d  = req_addr[win_idx*ADDR_BITS +: ADDR_BITS];
      pwrite_d = req_write[win_idx];
      pwdata_d = req_wdata[win_idx*DATA_BITS +: DATA_BITS];
    end else if (state_d == APB_IDLE) begin
      paddr_d  = '0;
      pwrite_d = 1'b0;
      pwdata_d = '0;
    end

    if (xfer_done) begin
      rsp_valid_d[owner_q] = 1'b1;
      rsp_rdata_d          = pwrite_q ? '0 : apb.prdata;
    end
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= APB_IDLE;
    else           state_q <= state_d;
  end

  // APB outputs, arbitration history and response registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= (state_d != APB_IDLE);
      penable_q   <= (state_d == APB_ACCESS);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (grant) begin
        owner_q <= win_idx;
        last_q  <= win_idx;
      end
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// Self-checking bench for amba3_apb_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_amba3_apb_arbiter;

  localparam int N = 4;
  localparam int A = 32;
  localparam int D = 32;

  logic           pclk = 1'b0;
  logic           preset_n;
  logic [N-1:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_wdata;
  logic [D-1:0]   rsp_rdata;

  int checks = 0;
  int passed = 0;

  amba3_apb_if #(.ADDR_BITS(A), .DATA_BITS(D)) apb ();

  amba3_apb_arbiter #(.NUM_REQ(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .apb       (apb)
  );

  always #5 pclk = ~pclk;

  task automatic set_req(input logic [1:0] i, input logic w, input logic [A-1:0] a,
                         input logic [D-1:0] d);
    req_write[i]           = w;
    req_addr[i*A +: A]     = a;
    req_wdata[i*D +: D]    = d;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset_n   = 1'b0;
    req_valid  = '0;
    apb.pready = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
  endtask

  task automatic test_reset();
    preset_n   = 1'b0;
    req_valid  = 4'hF;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    apb.pready = 1'b1;
    apb.prdata = 32'hFFFF_FFFF;
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== '0) begin
      $display("FAIL reset_apb got psel=%b pen=%b paddr=%h exp all zero", apb.psel, apb.penable, apb.paddr);
    end else passed++;
    checks++;
    if (req_ready !== 4'h0) $display("FAIL reset_ready got %b exp 0000", req_ready);
    else passed++;
    checks++;
    if ({rsp_valid, rsp_rdata} !== '0) $display("FAIL reset_rsp got v=%b d=%h exp 0", rsp_valid, rsp_rdata);
    else passed++;
    req_valid = '0;
    @(negedge pclk);
    preset_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge pclk);
    set_req(2'd0, 1'b0, 32'h100, 32'h0);
    req_valid  = 4'b0001;
    apb.pready = 1'b1;
    apb.prdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL read_ready got %b exp 0001", req_ready);
    else passed++;
    @(negedge pclk);
    req_valid = '0;
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr} !== {3'b100, 32'h100})
      $display("FAIL read_setup got psel=%b pen=%b wr=%b addr=%h exp 1 0 0 100",
               apb.psel, apb.penable, apb.pwrite, apb.paddr);
    else passed++;
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable} !== 2'b11) $display("FAIL read_access got %b%b exp 11", apb.psel, apb.penable);
    else passed++;
    @(negedge pclk);
    apb.prdata = 32'h1234_5678;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {4'b0001, 32'hDEAD_BEEF})
      $display("FAIL read_rsp got v=%b d=%h exp 0001 deadbeef", rsp_valid, rsp_rdata);
    else passed++;
    checks++;
    if ({apb.psel, apb.penable, apb.paddr} !== '0)
      $display("FAIL read_idle got psel=%b pen=%b addr=%h exp 0", apb.psel, apb.penable, apb.paddr);
    else passed++;
    @(negedge pclk);
    checks++;
    if ({rsp_valid, rsp_rdata} !== {4'b0000, 32'hDEAD_BEEF})
      $display("FAIL read_hold got v=%b d=%h exp 0000 deadbeef", rsp_valid, rsp_rdata);
    else passed++;
  endtask

  task automatic test_wait_states();
    @(negedge pclk);
    set_req(2'd2, 1'b1, 32'h20, 32'h55AA);
    req_valid  = 4'b0100;
    apb.pready = 1'b0;
    apb.prdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (req_ready !== 4'b0100) $display("FAIL wait_ready got %b exp 0100", req_ready);
    else passed++;
    @(negedge pclk);
    req_valid = '0;
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {3'b101, 32'h20, 32'h55AA})
      $display("FAIL wait_setup got psel=%b pen=%b wr=%b addr=%h wd=%h", apb.psel, apb.penable,
               apb.pwrite, apb.paddr, apb.pwdata);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      if (c == 3) apb.pready = 1'b1;
      checks++;
      if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, rsp_valid} !==
          {3'b111, 32'h20, 32'h55AA, 4'b0000})
        $display("FAIL wait_access[%0d] got psel=%b pen=%b wr=%b addr=%h wd=%h rv=%b", c, apb.psel,
                 apb.penable, apb.pwrite, apb.paddr, apb.pwdata, rsp_valid);
      else passed++;
    end
    @(negedge pclk);
    apb.pready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, apb.psel} !== {4'b0100, 32'h0, 1'b0})
      $display("FAIL wait_rsp got v=%b d=%h psel=%b exp 0100 0 0", rsp_valid, rsp_rdata, apb.psel);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ready, exp_rsp;
    do_reset();
    for (int i = 0; i < N; i++) set_req(2'(i), 1'b0, 32'(i * 16 + 'h400), 32'h0);
    apb.pready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge pclk);
      if (c == 0) req_valid = 4'hF;
      #1;
      exp_ready = (c % 2 == 0) ? 4'(1 << ((c / 2) % N)) : 4'h0;
      checks++;
      if (req_ready !== exp_ready) $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready, exp_ready);
      else passed++;
      if (c > 0) begin
        checks++;
        if ({apb.psel, apb.penable} !== {1'b1, c % 2 == 0})
          $display("FAIL rr_phase[%0d] got psel=%b pen=%b exp 1 %0d", c, apb.psel, apb.penable, c % 2 == 0);
        else passed++;
      end
      if (c >= 3 && c % 2 == 1) begin
        exp_rsp = 4'(1 << (((c - 3) / 2) % N));
        checks++;
        if (rsp_valid !== exp_rsp) $display("FAIL rr_rsp[%0d] got %b exp %b", c, rsp_valid, exp_rsp);
        else passed++;
      end
    end
  endtask

  task automatic test_owner_rerequest();
    do_reset();
    set_req(2'd1, 1'b0, 32'h1000, 32'h0);
    set_req(2'd3, 1'b1, 32'h3000, 32'h33);
    apb.pready = 1'b1;
    @(negedge pclk);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL rereq_first got %b exp 0010", req_ready);
    else passed++;
    @(negedge pclk);
    #1;
    checks++;
    if ({req_ready, apb.paddr} !== {4'b0000, 32'h1000})
      $display("FAIL rereq_setup got ready=%b addr=%h exp 0000 1000", req_ready, apb.paddr);
    else passed++;
    @(negedge pclk);
    #1;
    checks++;
    if (req_ready !== 4'b1000) $display("FAIL rereq_second got %b exp 1000", req_ready);
    else passed++;
    @(negedge pclk);
    req_valid = 4'b0010;
    checks++;
    if ({apb.psel, apb.penable, apb.paddr} !== {2'b10, 32'h3000})
      $display("FAIL rereq_setup3 got psel=%b pen=%b addr=%h exp 1 0 3000", apb.psel, apb.penable, apb.paddr);
    else passed++;
    @(negedge pclk);
    #1;
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL rereq_third got %b exp 0010", req_ready);
    else passed++;
    @(negedge pclk);
    req_valid = '0;
    @(negedge pclk);
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    set_req(2'd1, 1'b0, 32'h111, 32'h0);
    set_req(2'd2, 1'b1, 32'h222, 32'h2222);
    set_req(2'd3, 1'b0, 32'h333, 32'h0);
    apb.pready = 1'b0;
    @(negedge pclk);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL mid_grant got %b exp 0010", req_ready);
    else passed++;
    @(negedge pclk);
    req_valid = 4'b1100;
    #1;
    checks++;
    if (req_ready !== 4'b0000) $display("FAIL mid_setup_wait got %b exp 0000", req_ready);
    else passed++;
    @(negedge pclk);
    #1;
    checks++;
    if ({req_ready, apb.psel, apb.penable} !== {4'b0000, 2'b11})
      $display("FAIL mid_access got ready=%b psel=%b pen=%b exp 0000 1 1", req_ready, apb.psel, apb.penable);
    else passed++;
    @(negedge pclk);
    #2;
    preset_n = 1'b0;
    #1;
    checks++;
    if ({apb.psel, apb.penable, req_ready, rsp_valid} !== '0)
      $display("FAIL mid_async_rst got psel=%b pen=%b ready=%b rv=%b exp 0", apb.psel, apb.penable,
               req_ready, rsp_valid);
    else passed++;
    @(negedge pclk);
    apb.pready = 1'b1;
    preset_n   = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) $display("FAIL mid_after_rst got %b exp 0100", req_ready);
    else passed++;
    @(negedge pclk);
    req_valid = 4'b1000;
    checks++;
    if ({rsp_valid, apb.psel, apb.paddr} !== {4'b0000, 1'b1, 32'h222})
      $display("FAIL mid_no_rsp got rv=%b psel=%b addr=%h exp 0000 1 222", rsp_valid, apb.psel, apb.paddr);
    else passed++;
  endtask

  task automatic test_random();
    int           m_last, m_owner, m_age, winner;
    bit           m_active, m_wr, done, can;
    logic [1:0]   ci;
    logic         e_psel, e_pen, e_pwr;
    logic [A-1:0] e_paddr;
    logic [D-1:0] e_pwdata, e_rdata;
    logic [N-1:0] e_rsp, e_ready, granted;
    do_reset();
    m_last = N - 1; m_owner = 0; m_age = 0; m_active = 0; m_wr = 0;
    e_psel = 0; e_pen = 0; e_pwr = 0; e_paddr = '0; e_pwdata = '0; e_rdata = '0;
    e_rsp = '0; granted = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge pclk);
      checks++;
      if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {e_psel, e_pen, e_pwr, e_paddr, e_pwdata})
        $display("FAIL rnd_apb cyc=%0d got %b%b%b %h %h exp %b%b%b %h %h", cyc, apb.psel, apb.penable,
                 apb.pwrite, apb.paddr, apb.pwdata, e_psel, e_pen, e_pwr, e_paddr, e_pwdata);
      else passed++;
      checks++;
      if ({rsp_valid, rsp_rdata} !== {e_rsp, e_rdata})
        $display("FAIL rnd_rsp cyc=%0d got %b %h exp %b %h", cyc, rsp_valid, rsp_rdata, e_rsp, e_rdata);
      else passed++;

      for (int i = 0; i < N; i++) begin
        if (!req_valid[2'(i)] || granted[2'(i)]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[2'(i)] = 1'b1;
            set_req(2'(i), 1'($urandom_range(0, 1)), $urandom, $urandom);
          end else req_valid[2'(i)] = 1'b0;
        end
      end
      apb.pready = ($urandom_range(0, 2) != 0);
      apb.prdata = $urandom;
      #1;

      done   = m_active && m_age >= 1 && apb.pready;
      can    = !m_active || done;
      winner = -1;
      if (can) begin
        for (int k = 1; k <= N; k++) begin
          ci = 2'((m_last + k) % N);
          if (winner < 0 && req_valid[ci]) winner = int'(ci);
        end
      end
      e_ready = (winner >= 0) ? 4'(1 << winner) : 4'h0;
      checks++;
      if (req_ready !== e_ready) $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, req_ready, e_ready);
      else passed++;
      granted = e_ready;

      e_rsp = done ? 4'(1 << m_owner) : 4'h0;
      if (done) e_rdata = m_wr ? 32'h0 : apb.prdata;
      if (winner >= 0) begin
        ci       = 2'(winner);
        m_active = 1; m_age = 0; m_owner = winner; m_last = winner; m_wr = req_write[ci];
        e_psel   = 1'b1; e_pen = 1'b0; e_pwr = req_write[ci];
        e_paddr  = req_addr[winner*A +: A];
        e_pwdata = req_wdata[winner*D +: D];
      end else if (done) begin
        m_active = 0;
        e_psel = 1'b0; e_pen = 1'b0; e_pwr = 1'b0; e_paddr = '0; e_pwdata = '0;
      end else if (m_active) begin
        m_age++;
        e_pen = 1'b1;
      end
    end
    @(negedge pclk);
    req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_wait_states();
    test_round_robin();
    test_owner_rerequest();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/amba3_apb_arbiter.md
# amba3_apb_arbiter

Shares one AMBA 3 APB master port among `NUM_REQ` local requesters. Round-robin arbitration picks one requester per transfer and sequences the APB SETUP/ACCESS phases. It holds ACCESS through slave wait states and returns read data with a completion pulse. It sits between on-chip masters (DMA and config engines, CPU bridge) and the APB slave fabric, and is driven by the `amba3_apb_if` master-side signal set.

## Interface

Parameters:

- `NUM_REQ`, 4: number of requesters, 2..16.
- `ADDR_BITS`, 32: `paddr` width.
- `DATA_BITS`, 32: `pwdata`/`prdata` width.

Ports:

- `pclk`, in, 1: clock. One clock domain; all logic on rising edge.
- `preset_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, `NUM_REQ`: request pending, one bit per requester.
- `req_ready`, out, `NUM_REQ`: request accepted, one-hot, combinational.
- `req_write`, in, `NUM_REQ`: 1 = write, 0 = read.
- `req_addr`, in, `NUM_REQ*ADDR_BITS`: packed addresses, requester i at `[i*ADDR_BITS +: ADDR_BITS]`.
- `req_wdata`, in, `NUM_REQ*DATA_BITS`: packed write data, same packing.
- `rsp_valid`, out, `NUM_REQ`: one-cycle completion pulse, one-hot, registered.
- `rsp_rdata`, out, `DATA_BITS`: read data for the current `rsp_valid`; 0 for writes.
- `paddr`, `psel`, `penable`, `pwrite`, `pwdata`: out, APB master outputs, registered.
- `pready`, `prdata`: in, APB slave responses.

## Operation

- FSM states:
  - IDLE: `psel` = 0.
  - SETUP: `psel` = 1, `penable` = 0.
  - ACCESS: `psel` = 1, `penable` = 1.
- Grant point: a cycle where the state is IDLE, or ACCESS with `pready` = 1, and `req_valid` is non-zero.
  - Winner = first set bit of `req_valid` searching upward from `last_grant + 1`, modulo `NUM_REQ`.
  - `req_ready[winner]` = 1 in that same cycle.
  - Winner's addr/write/wdata are latched onto the APB outputs; next state is SETUP; `last_grant` ← winner.
- SETUP → ACCESS unconditionally after 1 cycle.
- ACCESS with `pready` = 0: hold state; all APB outputs stay stable.
- ACCESS with `pready` = 1: transfer completes.
  - Next cycle `rsp_valid[owner]` = 1 and `rsp_rdata` = `prdata` (read) or 0 (write).
  - Next state is SETUP if a grant occurs in this cycle (back-to-back), else IDLE.
  - On return to IDLE: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata` = 0.
- `rsp_rdata` holds its value until the next completion.
- Requester rules:
  - Keep `req_valid` and its fields stable until `req_ready` is seen.
  - Dropping `req_valid` before `req_ready` is illegal.
  - The handshake completes when `req_valid & req_ready` are both high.
- Requests on `req_valid` during SETUP or ACCESS without `pready` are not granted; they wait.
- The owner may re-request immediately. It wins at the next grant point only if no other requester is valid, which gives fairness.
- Reset (any time, including mid-transfer):
  - State → IDLE; `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
  - All outputs → 0; an in-flight transfer is abandoned with no `rsp_valid`.

## Timing

- Latency, idle bus: `req_valid` seen in cycle 0 → `req_ready` in cycle 0 → `psel` in cycle 1 → `penable` in cycle 2.
  - With `pready` = 1 in cycle 2, `rsp_valid` is in cycle 3.
  - Minimum 3 cycles request-to-response; each wait state adds 1.
- Back-to-back throughput: one transfer per 2 cycles. `psel` stays high; `penable` drops for the SETUP cycle.
- `pready` is sampled only in ACCESS; it is ignored in IDLE and SETUP.

## Structure

- Shared package `pkg_amba3` gets:
  - `typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t`.
  - Round-robin helper function, or keep it in the sub-module.
- Sub-module `amba3_rr_arbiter`: parameter `N`; inputs `req[N]`, `ptr` (last grant), `en`; outputs one-hot `gnt[N]` and `gnt_idx`. Purely combinational; `last_grant` is held in the parent.
- Parent holds: FSM, owner index register, APB output registers, response registers.

## Test plan

- Single read: `req_valid` = 4'b0001, addr 0x100, slave `pready` = 1 at first ACCESS, `prdata` = 0xDEADBEEF.
  - Expect `req_ready[0]` in cycle 0, `psel` in cycle 1, `penable` in cycle 2, `rsp_valid` = 4'b0001 with `rsp_rdata` = 0xDEADBEEF in cycle 3.
- Wait states: write 0x55AA to 0x20 from requester 2 with `pready` low for 3 ACCESS cycles.
  - Expect APB outputs stable for 4 ACCESS cycles and `rsp_valid[2]` one cycle after `pready`.
  - Expect `rsp_rdata` = 0.
- Round robin: all 4 requesters valid continuously from reset.
  - Expect grant order 0, 1, 2, 3, 0; back-to-back with `psel` never dropping; `penable` toggling 0/1.
- Owner re-request: requesters 1 and 3 valid, 1 granted and re-requests.
  - Expect next grant to 3, then 1.
- Reset mid-ACCESS: assert `preset_n` = 0 while `pready` = 0.
  - Expect `psel`, `penable`, `req_ready`, `rsp_valid` = 0 immediately (asynchronous).
  - After release, the first grant goes to the lowest valid index.
